// File: rtl/dice_pkg.sv
// Shared definitions for the dice roll controller: FSM encoding, default
// die geometry and a width helper for counters sized from parameters.
package dice_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SPIN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_FACES       = 6;
   localparam int DEF_SPIN_CYCLES = 4;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int clog2w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/dice_mod_cnt.sv
// Free-running modulo-FACES counter producing the raw die face 0..FACES-1.
// It never stalls; only the synchronous reset returns it to zero.
module dice_mod_cnt
   import dice_pkg::*;
#(
   parameter int FACES = DEF_FACES,
   parameter int W     = clog2w(FACES)
) (
   input  logic         clk,
   input  logic         rst,
   output logic [W-1:0] cnt
);

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt == W'(FACES - 1)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/dice_roll_ctrl.sv
// Round-robin arbiter sharing one spinning die between N_REQ players.
// Optional build macro ROLL_SUM_EN adds the n_dice port and multi-die sums.
module dice_roll_ctrl
   import dice_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int ID_W        = 2,
   parameter int FACES       = DEF_FACES,
   parameter int SPIN_CYCLES = DEF_SPIN_CYCLES,
   parameter int SUM_W       = 6
`ifdef ROLL_SUM_EN
   ,
   parameter int MAX_DICE    = 8,
   parameter int ND_W        = 3
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] ack,
   output logic [ID_W-1:0]  grant_id,
   output logic             busy,
   output logic             valid,
   output logic [SUM_W-1:0] value
`ifdef ROLL_SUM_EN
   ,
   input  logic [ND_W-1:0]  n_dice
`endif
);

   localparam int CNT_W  = clog2w(FACES);
   localparam int SPIN_W = clog2w(SPIN_CYCLES);
   localparam int IDX_W  = ID_W + 1;
   localparam logic [SPIN_W-1:0] SPIN_LOAD = SPIN_W'(SPIN_CYCLES - 1);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [SPIN_W-1:0]  spin_ctr, spin_nxt;
   logic [ID_W-1:0]    ptr, ptr_nxt, gid_nxt;
   logic [N_REQ-1:0]   ack_nxt;
   logic               valid_nxt;
   logic [SUM_W-1:0]   value_nxt;
   logic [SUM_W-1:0]   face;
   logic               rr_hit;
   logic [ID_W-1:0]    rr_pick;
   logic [IDX_W-1:0]   rr_idx;
   logic [IDX_W-1:0]   ptr_inc;

`ifdef ROLL_SUM_EN
   localparam int REM_W = clog2w(MAX_DICE);

   logic [SUM_W-1:0] acc, acc_nxt;
   logic [REM_W-1:0] dice_rem, rem_nxt;
   logic [REM_W-1:0] dice_first;
`endif

   dice_mod_cnt #(
      .FACES (FACES),
      .W     (CNT_W)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .cnt (cnt)
   );

   assign face = SUM_W'(cnt) + SUM_W'(1);
   assign busy = (state != IDLE);

   // Circular search: first asserted request at or after ptr.
   always_comb begin
      rr_hit  = 1'b0;
      rr_pick = '0;
      rr_idx  = '0;
      for (int j = 0; j < N_REQ; j++) begin
         rr_idx = {1'b0, ptr} + IDX_W'(j);
         if (rr_idx >= IDX_W'(N_REQ)) rr_idx = rr_idx - IDX_W'(N_REQ);
         if (!rr_hit && req[rr_idx[ID_W-1:0]]) begin
            rr_hit  = 1'b1;
            rr_pick = rr_idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      ptr_inc = {1'b0, grant_id} + IDX_W'(1);
      if (ptr_inc >= IDX_W'(N_REQ)) ptr_inc = '0;
   end

`ifdef ROLL_SUM_EN
   // Remaining dice after the first: 0 counts as one die, excess is clamped.
   always_comb begin
      dice_first = '0;
      if (n_dice == '0) begin
         dice_first = '0;
      end else if (int'(n_dice) > MAX_DICE) begin
         dice_first = REM_W'(MAX_DICE - 1);
      end else begin
         dice_first = REM_W'(int'(n_dice) - 1);
      end
   end
`endif

   // NOTE: every output of this block is defaulted first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      spin_nxt  = spin_ctr;
      gid_nxt   = grant_id;
      ptr_nxt   = ptr;
      value_nxt = value;
      ack_nxt   = '0;
      valid_nxt = 1'b0;
`ifdef ROLL_SUM_EN
      acc_nxt   = acc;
      rem_nxt   = dice_rem;
`endif

      unique case (state)
         IDLE: begin
            if (rr_hit) begin
               gid_nxt   = rr_pick;
               spin_nxt  = SPIN_LOAD;
               state_nxt = SPIN;
`ifdef ROLL_SUM_EN
               acc_nxt   = '0;
               rem_nxt   = dice_first;
`endif
            end
         end

         SPIN: begin
            if (spin_ctr != '0) begin
               spin_nxt = spin_ctr - SPIN_W'(1);
            end else begin
`ifdef ROLL_SUM_EN
               acc_nxt = acc + face;
               if (dice_rem != '0) begin
                  rem_nxt  = dice_rem - REM_W'(1);
                  spin_nxt = SPIN_LOAD;
               end else begin
                  value_nxt         = acc + face;
                  ack_nxt[grant_id] = 1'b1;
                  valid_nxt         = 1'b1;
                  state_nxt         = DONE;
               end
`else
               value_nxt         = face;
               ack_nxt[grant_id] = 1'b1;
               valid_nxt         = 1'b1;
               state_nxt         = DONE;
`endif
            end
         end

         DONE: begin
            ptr_nxt   = ptr_inc[ID_W-1:0];
            state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         spin_ctr <= '0;
         ptr      <= '0;
         grant_id <= '0;
         ack      <= '0;
         valid    <= 1'b0;
         value    <= '0;
`ifdef ROLL_SUM_EN
         acc      <= '0;
         dice_rem <= '0;
`endif
      end else begin
         state    <= state_nxt;
         spin_ctr <= spin_nxt;
         ptr      <= ptr_nxt;
         grant_id <= gid_nxt;
         ack      <= ack_nxt;
         valid    <= valid_nxt;
         value    <= value_nxt;
`ifdef ROLL_SUM_EN
         acc      <= acc_nxt;
         dice_rem <= rem_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed bench for dice_roll_ctrl (FACES=6, SPIN_CYCLES=4, four players).
// Edge numbers below count rising edges after reset is released.
module tb_dice_roll_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] ack;
   logic [1:0] grant_id;
   logic       busy;
   logic       valid;
   logic [5:0] value;
   logic [2:0] n_dice;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dice_roll_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .ack      (ack),
      .grant_id (grant_id),
      .busy     (busy),
      .valid    (valid),
      .value    (value)
`ifdef ROLL_SUM_EN
      ,
      .n_dice   (n_dice)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      ticks(2);
      rst = 1'b0;
   endtask

   initial begin
      rst    = 1'b1;
      req    = '0;
      n_dice = 3'd1;

      // Reset state
      ticks(2);
      check("rst_ack", ack, 4'b0000);
      check("rst_valid", valid, 1'b0);
      check("rst_value", value, 6'd0);
      check("rst_gid", grant_id, 2'd0);
      check("rst_busy", busy, 1'b0);

      // Single roll, player 0, c0=0 -> value 5 after edge 5
      rst = 1'b0;
      req = 4'b0001;
      tick();
      check("t1_busy_e1", busy, 1'b1);
      check("t1_ack_e1", ack, 4'b0000);
      ticks(3);
      check("t1_valid_e4", valid, 1'b0);
      tick();
      check("t1_ack_e5", ack, 4'b0001);
      check("t1_valid_e5", valid, 1'b1);
      check("t1_value_e5", value, 6'd5);
      check("t1_gid_e5", grant_id, 2'd0);
      req = 4'b0000;
      tick();
      check("t1_ack_e6", ack, 4'b0000);
      check("t1_valid_e6", valid, 1'b0);
      check("t1_value_hold", value, 6'd5);
      check("t1_busy_e6", busy, 1'b0);

      // Two players: 0 acked at edge 5, 1 granted at edge 7, acked at edge 11
      do_reset();
      req = 4'b0011;
      ticks(5);
      check("t2_ack0", ack, 4'b0001);
      req = 4'b0010;
      tick();
      check("t2_busy_e6", busy, 1'b0);
      tick();
      check("t2_gid_e7", grant_id, 2'd1);
      check("t2_busy_e7", busy, 1'b1);
      ticks(3);
      check("t2_valid_e10", valid, 1'b0);
      tick();
      check("t2_ack1", ack, 4'b0010);
      check("t2_value1", value, 6'd5);
      req = 4'b0000;
      tick();

      // All four held: order 0,1,2,3,0, one roll every 6 edges, c0=0 each time
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         logic [1:0] exp_id;
         logic [3:0] exp_ack;
         exp_id  = 2'(k % 4);
         exp_ack = 4'b0001 << exp_id;
         tick();
         check($sformatf("t3_gid_%0d", k), grant_id, exp_id);
         ticks(4);
         check($sformatf("t3_ack_%0d", k), ack, exp_ack);
         check($sformatf("t3_val_%0d", k), value, 6'd5);
         tick();
      end
      req = 4'b0000;

      // Reset at edge 3 mid-spin aborts the roll; a new request then completes
      do_reset();
      req = 4'b0010;
      ticks(2);
      check("t4_busy_e2", busy, 1'b1);
      check("t4_gid_e2", grant_id, 2'd1);
      rst = 1'b1;
      tick();
      check("t4_busy_rst", busy, 1'b0);
      check("t4_gid_rst", grant_id, 2'd0);
      check("t4_value_rst", value, 6'd0);
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check($sformatf("t4_noack_e%0d", i), {ack, 3'b000, valid}, 8'h00);
      end
      tick();
      check("t4_ack_new", ack, 4'b0010);
      check("t4_value_new", value, 6'd5);
      req = 4'b0000;
      tick();

      // One idle edge (c0=1), player 2 drops req mid-spin -> value 6 at edge 6
      do_reset();
      tick();
      req = 4'b0100;
      tick();
      check("t5_gid_e2", grant_id, 2'd2);
      tick();
      req = 4'b0000;
      ticks(2);
      check("t5_noack_e5", ack, 4'b0000);
      tick();
      check("t5_ack_e6", ack, 4'b0100);
      check("t5_valid_e6", valid, 1'b1);
      check("t5_value_e6", value, 6'd6);
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("t5_idle_%0d", i), busy, 1'b0);
      end

      // Two idle edges (c0=2), only player 3 -> search wraps past ptr, value 1
      do_reset();
      ticks(2);
      req = 4'b1000;
      tick();
      check("t6_gid_e3", grant_id, 2'd3);
      req = 4'b0000;
      ticks(4);
      check("t6_ack_e7", ack, 4'b1000);
      check("t6_value_e7", value, 6'd1);
      tick();

`ifdef ROLL_SUM_EN
      // Two dice from c0=0: faces 5 and 3, single valid after edge 9
      do_reset();
      n_dice = 3'd2;
      req    = 4'b0001;
      ticks(5);
      check("s1_novalid_e5", valid, 1'b0);
      req = 4'b0000;
      ticks(3);
      check("s1_novalid_e8", valid, 1'b0);
      tick();
      check("s1_valid_e9", valid, 1'b1);
      check("s1_value_e9", value, 6'd8);
      tick();

      // n_dice=0 behaves as one die
      do_reset();
      n_dice = 3'd0;
      req    = 4'b0001;
      ticks(5);
      check("s2_valid_e5", valid, 1'b1);
      check("s2_value_e5", value, 6'd5);
      req = 4'b0000;
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
